// File: rtl/switch_port_arbiter.sv
// Round-robin arbiter and frame sequencer feeding the L2 forwarding stage from four node queues.
// Optional ARB_DROP_SELF_EN: frames with dst==src are consumed and counted as drops, not forwarded.
module switch_port_arbiter #(
  parameter int unsigned FRAME_W    = 12,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 FPGA_CLK,
  input  logic                 FPGA_RST_BTN,
  input  logic [3:0]           req_valid,
  input  logic [4*FRAME_W-1:0] req_frame,
  output logic [3:0]           req_ready,
  output logic                 out_valid,
  output logic [FRAME_W-1:0]   out_frame,
  output logic [1:0]           out_port,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     fwd_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Unreachable when GAP_CYCLES is 0: the GAP state is never entered.
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e             state_q;
  logic [1:0]         rr_ptr_q;
  logic [GapW-1:0]    gap_cnt_q;
  logic [3:0]         req_ready_q;
  logic               out_valid_q;
  logic [FRAME_W-1:0] out_frame_q;
  logic [1:0]         out_port_q;
  logic               busy_q;
  logic [CNT_W-1:0]   fwd_cnt_q;
  logic [CNT_W-1:0]   drop_cnt_q;

  logic [1:0]         winner;
  logic [FRAME_W-1:0] win_frame;
  logic               is_self;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    winner = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[rr_ptr_q + 2'(i)]) winner = rr_ptr_q + 2'(i);
    end
  end

  assign win_frame = req_frame[int'(winner)*FRAME_W +: FRAME_W];

`ifdef ARB_DROP_SELF_EN
  assign is_self = (win_frame[FRAME_W-1 -: 4] == win_frame[FRAME_W-5 -: 4]);
`else
  assign is_self = 1'b0;
`endif

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      out_frame_q <= '0;
      out_port_q  <= '0;
      busy_q      <= 1'b0;
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        StIdle: begin
          if (|req_valid) begin
            req_ready_q <= 4'b0001 << winner;
            rr_ptr_q    <= winner + 2'd1;
            out_frame_q <= win_frame;
            out_port_q  <= winner;
            gap_cnt_q   <= '0;
            if (is_self) begin
              drop_cnt_q <= drop_cnt_q + 1'b1;
              if (GAP_CYCLES > 0) begin
                state_q <= StGap;
                busy_q  <= 1'b1;
              end
            end else begin
              state_q     <= StSend;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        StSend: begin
          if (out_ready) begin
            fwd_cnt_q   <= fwd_cnt_q + 1'b1;
            out_valid_q <= 1'b0;
            gap_cnt_q   <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_frame = out_frame_q;
  assign out_port  = out_port_q;
  assign busy      = busy_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Bench for switch_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin order, frame queue, arbiter-free time).
module tb_switch_port_arbiter;

  localparam int unsigned FRAME_W = 12;
  localparam int unsigned GAP     = 2;
  localparam int unsigned CNT_W   = 8;

  logic               FPGA_CLK;
  logic               FPGA_RST_BTN;
  logic [3:0]         req_valid;
  logic [4*FRAME_W-1:0] req_frame;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic [FRAME_W-1:0] out_frame;
  logic [1:0]         out_port;
  logic               out_ready;
  logic               busy;
  logic [CNT_W-1:0]   fwd_cnt;
  logic [CNT_W-1:0]   drop_cnt;

  logic [FRAME_W-1:0] fr [4];

  int n_checks;
  int n_fail;

  assign req_frame = {fr[3], fr[2], fr[1], fr[0]};

  switch_port_arbiter #(
    .FRAME_W    (FRAME_W),
    .GAP_CYCLES (GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .FPGA_CLK     (FPGA_CLK),
    .FPGA_RST_BTN (FPGA_RST_BTN),
    .req_valid    (req_valid),
    .req_frame    (req_frame),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_frame    (out_frame),
    .out_port     (out_port),
    .out_ready    (out_ready),
    .busy         (busy),
    .fwd_cnt      (fwd_cnt),
    .drop_cnt     (drop_cnt)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  task automatic do_reset();
    @(negedge FPGA_CLK);
    FPGA_RST_BTN = 1'b0;
    req_valid    = '0;
    out_ready    = 1'b0;
    for (int i = 0; i < 4; i++) fr[i] = '0;
    repeat (2) @(negedge FPGA_CLK);
    FPGA_RST_BTN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge FPGA_CLK);
    FPGA_RST_BTN = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b0;
    fr[0] = 12'hBA1; fr[1] = 12'hCB2; fr[2] = 12'hDC3; fr[3] = 12'hAD4;
    repeat (2) @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (fwd_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_fwd_cnt got %0d want 0", fwd_cnt); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (out_frame !== 12'h000 || out_port !== 2'd0) begin n_fail++; $display("FAIL reset_out_data got %h/%0d want 000/0", out_frame, out_port); end
    FPGA_RST_BTN = 1'b1;
    @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant got %b want 0001", req_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid got %b want 1", out_valid); end
    n_checks++; if (out_frame !== 12'hBA1 || out_port !== 2'd0) begin n_fail++; $display("FAIL first_frame got %h/%0d want ba1/0", out_frame, out_port); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got %b want 1", busy); end
  endtask

  task automatic test_single_port();
    int busy_n, ov_n;
    do_reset();
    req_valid = 4'b0100;
    fr[2]     = 12'hCA5;
    out_ready = 1'b1;
    @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", req_ready); end
    n_checks++; if (out_frame !== 12'hCA5 || out_port !== 2'd2) begin n_fail++; $display("FAIL single_frame got %h/%0d want ca5/2", out_frame, out_port); end
    req_valid = 4'b0000;
    busy_n = int'(busy);
    ov_n   = int'(out_valid);
    for (int k = 0; k < 5; k++) begin
      @(negedge FPGA_CLK);
      busy_n += int'(busy);
      ov_n   += int'(out_valid);
    end
    n_checks++; if (busy_n != 3) begin n_fail++; $display("FAIL single_busy_cycles got %0d want 3", busy_n); end
    n_checks++; if (ov_n != 1) begin n_fail++; $display("FAIL single_valid_cycles got %0d want 1", ov_n); end
    n_checks++; if (fwd_cnt !== 8'd1) begin n_fail++; $display("FAIL single_fwd_cnt got %0d want 1", fwd_cnt); end
  endtask

  task automatic test_round_robin();
    int g_port [8];
    int g_cyc  [8];
    int ng;
    ng = 0;
    do_reset();
    req_valid = 4'hF;
    fr[0] = 12'hBA0; fr[1] = 12'hCB1; fr[2] = 12'hDC2; fr[3] = 12'hAD3;
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge FPGA_CLK);
      if (req_ready != 4'b0000 && ng < 8) begin
        n_checks++; if (!$onehot(req_ready)) begin n_fail++; $display("FAIL rr_onehot got %b want one-hot", req_ready); end
        for (int p = 0; p < 4; p++) if (req_ready[p]) g_port[ng] = p;
        g_cyc[ng] = k;
        n_checks++; if (out_port !== 2'(g_port[ng])) begin n_fail++; $display("FAIL rr_out_port got %0d want %0d", out_port, g_port[ng]); end
        ng++;
      end
    end
    n_checks++; if (ng < 5) begin n_fail++; $display("FAIL rr_grant_count got %0d want >=5", ng); end
    for (int g = 0; g < 5 && g < ng; g++) begin
      n_checks++; if (g_port[g] != g % 4) begin n_fail++; $display("FAIL rr_order grant %0d got port %0d want %0d", g, g_port[g], g % 4); end
      if (g > 0) begin
        n_checks++;
        if (g_cyc[g] - g_cyc[g-1] != 2 + int'(GAP)) begin
          n_fail++; $display("FAIL rr_spacing grant %0d got %0d want %0d", g, g_cyc[g] - g_cyc[g-1], 2 + GAP);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic bad_ov, bad_fr, bad_rdy, bad_cnt;
    bad_ov = 0; bad_fr = 0; bad_rdy = 0; bad_cnt = 0;
    do_reset();
    req_valid = 4'b0010;
    fr[1]     = 12'hDB7;
    out_ready = 1'b0;
    @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant got %b want 0010", req_ready); end
    for (int k = 0; k < 10; k++) begin
      @(negedge FPGA_CLK);
      if (out_valid !== 1'b1) bad_ov = 1;
      if (out_frame !== 12'hDB7) bad_fr = 1;
      if (req_ready !== 4'b0000) bad_rdy = 1;
      if (fwd_cnt !== 8'd0) bad_cnt = 1;
    end
    n_checks++; if (bad_ov) begin n_fail++; $display("FAIL stall_out_valid got dropped want held 1"); end
    n_checks++; if (bad_fr) begin n_fail++; $display("FAIL stall_out_frame got changed want held db7"); end
    n_checks++; if (bad_rdy) begin n_fail++; $display("FAIL stall_req_ready got pulse want none"); end
    n_checks++; if (bad_cnt) begin n_fail++; $display("FAIL stall_fwd_cnt got nonzero want 0"); end
    out_ready = 1'b1;
    @(negedge FPGA_CLK);
    n_checks++; if (fwd_cnt !== 8'd1) begin n_fail++; $display("FAIL stall_release_fwd got %0d want 1", fwd_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b want 0", out_valid); end
    req_valid = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b0100;
    fr[2]     = 12'hAC1;
    fr[0]     = 12'hBA9;
    out_ready = 1'b0;
    @(negedge FPGA_CLK);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
    req_valid = 4'hF;
    #2 FPGA_RST_BTN = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got valid=%b busy=%b want 0/0", out_valid, busy); end
    @(negedge FPGA_CLK);
    FPGA_RST_BTN = 1'b1;
    @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0001 || out_port !== 2'd0) begin n_fail++; $display("FAIL arst_restart got %b/%0d want 0001/0", req_ready, out_port); end
  endtask

  task automatic test_drop_self();
    int ov_n;
    do_reset();
    req_valid = 4'b0010;
    fr[1]     = 12'hBB5;
    out_ready = 1'b1;
    @(negedge FPGA_CLK);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL self_grant got %b want 0010", req_ready); end
    req_valid = 4'b0000;
    ov_n = int'(out_valid);
    for (int k = 0; k < 5; k++) begin
      @(negedge FPGA_CLK);
      ov_n += int'(out_valid);
    end
`ifdef ARB_DROP_SELF_EN
    n_checks++; if (ov_n != 0) begin n_fail++; $display("FAIL self_valid_cycles got %0d want 0", ov_n); end
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL self_drop_cnt got %0d want 1", drop_cnt); end
    n_checks++; if (fwd_cnt !== 8'd0) begin n_fail++; $display("FAIL self_fwd_cnt got %0d want 0", fwd_cnt); end
`else
    n_checks++; if (ov_n != 1) begin n_fail++; $display("FAIL self_valid_cycles got %0d want 1", ov_n); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL self_drop_cnt got %0d want 0", drop_cnt); end
    n_checks++; if (fwd_cnt !== 8'd1) begin n_fail++; $display("FAIL self_fwd_cnt got %0d want 1", fwd_cnt); end
`endif
  endtask

  // Model: round-robin pointer, at most one outstanding frame, and the earliest clock edge at
  // which the arbiter may grant again (GAP+1 edges after a frame leaves or is dropped).
  task automatic test_random();
    int                 rr, free_e, exp_fwd, exp_drop, w;
    logic               pending, drop;
    logic [3:0]         exp_rdy;
    logic [FRAME_W-1:0] exp_frame;
    logic [1:0]         exp_port;
    rr = 0; free_e = 0; exp_fwd = 0; exp_drop = 0; pending = 0;
    exp_frame = '0; exp_port = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = 1'($urandom_range(0, 1));
      fr[i] = 12'($urandom_range(0, 4095));
    end
    out_ready = 1'($urandom_range(0, 3) != 0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge FPGA_CLK);
      exp_rdy = '0;
      if (pending) begin
        if (out_ready) begin
          pending = 0;
          exp_fwd++;
          free_e = n + int'(GAP) + 1;
        end
      end else if (n >= free_e && req_valid != 4'b0000) begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && req_valid[(rr + k) % 4]) w = (rr + k) % 4;
        exp_rdy[w] = 1'b1;
        rr = (w + 1) % 4;
`ifdef ARB_DROP_SELF_EN
        drop = (fr[w][11:8] == fr[w][7:4]);
`else
        drop = 1'b0;
`endif
        if (drop) begin
          exp_drop++;
          free_e = n + int'(GAP) + 1;
        end else begin
          pending   = 1;
          exp_frame = fr[w];
          exp_port  = 2'(w);
        end
      end
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_req_ready edge %0d got %b want %b", n, req_ready, exp_rdy); end
      n_checks++; if (out_valid !== pending) begin n_fail++; $display("FAIL rand_out_valid edge %0d got %b want %b", n, out_valid, pending); end
      if (pending) begin
        n_checks++;
        if (out_frame !== exp_frame || out_port !== exp_port) begin
          n_fail++; $display("FAIL rand_out_data edge %0d got %h/%0d want %h/%0d", n, out_frame, out_port, exp_frame, exp_port);
        end
      end
      n_checks++; if (fwd_cnt !== CNT_W'(exp_fwd)) begin n_fail++; $display("FAIL rand_fwd_cnt edge %0d got %0d want %0d", n, fwd_cnt, CNT_W'(exp_fwd)); end
      n_checks++; if (drop_cnt !== CNT_W'(exp_drop)) begin n_fail++; $display("FAIL rand_drop_cnt edge %0d got %0d want %0d", n, drop_cnt, CNT_W'(exp_drop)); end
      n_checks++; if (busy !== (pending || (n + 1 < free_e))) begin n_fail++; $display("FAIL rand_busy edge %0d got %b want %b", n, busy, (pending || (n + 1 < free_e))); end
      // Requesters: hold until consumed, occasionally withdraw; then maybe present a new frame.
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          fr[i] = 12'($urandom_range(0, 4095));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    FPGA_RST_BTN = 1'b0;
    req_valid    = '0;
    out_ready    = 1'b0;
    for (int i = 0; i < 4; i++) fr[i] = '0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_async_reset();
    test_drop_self();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
